ahb_bram_ctrl: RTL and testbench

- AHB-Lite slave controller that sequences the dual-port block RAM: port A (byte-masked write), port B (registered read).
- Converts CPU bus transfers into RAM write and read cycles with zero-wait reads.
- Shares the RAM write port with a program-loader stream (UART boot path), and inserts one wait state on read-after-write hazards.
- Sits between the Cortex-M0 bus matrix and the RAM instance.

---
 rtl/ahb_bram_ctrl_pkg.sv | 35 +++
 rtl/ahb_bram_ctrl_if.sv | 25 ++
 rtl/ahb_bram_ctrl.sv | 94 +++++++++
 tb/tb_ahb_bram_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared AHB-Lite encodings, controller FSM states and the byte-lane mask helper
// for the block-RAM controller.
package ahb_bram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_STALL
    } state_e;

    // Byte enables for a transfer; any size wider than a word writes the full word.
    function automatic logic [STRB_W-1:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
        logic [STRB_W-1:0] m;
        case (size)
            HSIZE_BYTE: m = STRB_W'(4'b0001 << off);
            HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite slave-side bus bundle seen by the block-RAM controller.
interface ahb_bram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRDATA, HRESP
    );

endinterface

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave sequencing a dual-port block RAM: CPU and program loader share
// write port A, reads use port B with one wait state on read-after-write hazards.
module ahb_bram_ctrl
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    ahb_bram_ctrl_if.slave        ahb,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  ld_ready,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_W-1:0]     bram_dina,
    output logic [STRB_W-1:0]     bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [DATA_W-1:0]     bram_doutb
);

    state_e                state_q;
    logic                  hreadyout_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_W-1:0]     mask_q;

    logic                  acc;
    logic                  hazard;
    logic [ADDR_WIDTH-1:0] haddr_word;

    assign acc        = ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
    assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];

    // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    // Write-port arbitration: a CPU data phase always beats the loader.
    always_comb begin
        bram_addra = ld_addr;
        bram_dina  = ld_data;
        bram_wea   = '0;
        ld_ready   = (state_q != ST_WRITE);
        if (state_q == ST_WRITE) begin
            bram_addra = addr_q;
            bram_dina  = ahb.HWDATA;
            bram_wea   = mask_q;
        end else if (ld_valid) begin
            bram_wea   = '1;
        end
    end

    // A read accepted against a same-cycle write would see stale read-first data.
    assign hazard = acc && !ahb.HWRITE && (bram_wea != '0) && (bram_addra == haddr_word);

    assign bram_addrb    = (state_q == ST_STALL) ? addr_q : haddr_word;
    assign ahb.HRDATA    = bram_doutb;
    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            addr_q      <= '0;
            mask_q      <= '0;
        end else begin
            if (acc) begin
                addr_q <= haddr_word;
                mask_q <= byte_mask(ahb.HSIZE, ahb.HADDR[1:0]);
            end
            case (state_q)
                ST_STALL: begin
                    state_q     <= ST_READ;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    hreadyout_q <= 1'b1;
                    if (acc && ahb.HWRITE) begin
                        state_q <= ST_WRITE;
                    end else if (hazard) begin
                        state_q     <= ST_STALL;
                        hreadyout_q <= 1'b0;
                    end else if (acc) begin
                        state_q <= ST_READ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed scenarios plus random bus/loader traffic,
// checked against a word-array memory model and per-cycle port expectations.
module tb_ahb_bram_ctrl;
    import ahb_bram_ctrl_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_bram_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ahb        (bus),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    // Read-first dual-port RAM placed beside the controller.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        bram_doutb <= ram[bram_addrb];
        for (int b = 0; b < 4; b++)
            if (bram_wea[b]) ram[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
    end

    logic [31:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    // Outstanding data phase as seen by the bench.
    logic          p_valid = 1'b0, p_write = 1'b0, p_hz = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [3:0]    p_mask = '0;
    logic [31:0]   p_wdata = '0, p_exp = '0, last_rd = '0;
    int            stall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] off);
        if (size == 3'd0) return 4'(1 << off);
        if (size == 3'd1) return off[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    task automatic drive(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                         input logic [31:0] haddr, input logic [2:0] hsize, input logic [31:0] hwdata,
                         input logic lv, input logic [AW-1:0] la, input logic [31:0] ldat);
        bus.HSEL = hsel; bus.HTRANS = htrans; bus.HWRITE = hwrite;
        bus.HADDR = haddr; bus.HSIZE = hsize; bus.HWDATA = hwdata;
        ld_valid = lv; ld_addr = la; ld_data = ldat;
    endtask

    // One bus cycle: presents a new address phase plus the pending data phase and loader request.
    task automatic cycle(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                         input logic [31:0] haddr, input logic [2:0] hsize, input logic [31:0] wdata,
                         input logic lv, input logic [AW-1:0] la, input logic [31:0] ldat,
                         output logic ld_acc);
        logic          nv;
        logic [AW-1:0] nw, ea;
        logic [3:0]    ew;
        logic [31:0]   ed;
        nv = hsel && htrans[1];
        nw = haddr[AW+1:2];
        if (p_valid && !p_write && p_hz) begin
            drive(hsel, htrans, hwrite, haddr, hsize, $urandom, 1'b0, la, ldat);
            @(negedge clk);
            check("stall_hreadyout", 32'(bus.HREADYOUT), 32'd0);
            check("stall_ld_ready", 32'(ld_ready), 32'd1);
            check("stall_wea", 32'(bram_wea), 32'd0);
            check("stall_addrb", 32'(bram_addrb), 32'(p_addr));
            stall_cnt++;
            @(posedge clk); #1;
        end
        drive(hsel, htrans, hwrite, haddr, hsize, (p_valid && p_write) ? p_wdata : $urandom, lv, la, ldat);
        @(negedge clk);
        check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("hresp", 32'(bus.HRESP), 32'd0);
        if (p_valid && !p_write) begin
            last_rd = bus.HRDATA;
            check("hrdata", bus.HRDATA, p_exp);
        end
        if (p_valid && p_write) begin
            ew = p_mask; ea = p_addr; ed = p_wdata; ld_acc = 1'b0;
            check("ld_ready_wr", 32'(ld_ready), 32'd0);
        end else begin
            ew = lv ? 4'hF : 4'h0; ea = la; ed = ldat; ld_acc = lv;
            check("ld_ready", 32'(ld_ready), 32'd1);
        end
        check("wea", 32'(bram_wea), 32'(ew));
        if (ew != 4'h0) begin
            check("addra", 32'(bram_addra), 32'(ea));
            check("dina", bram_dina, ed);
        end
        if (nv && !hwrite) check("addrb", 32'(bram_addrb), 32'(nw));
        p_hz = nv && !hwrite && (ew != 4'h0) && (ea == nw);
        for (int b = 0; b < 4; b++)
            if (ew[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
        p_valid = nv; p_write = hwrite; p_addr = nw;
        p_mask  = lanes(hsize, haddr[1:0]); p_wdata = wdata;
        p_exp   = ref_mem[nw];
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        logic acc;
        cycle(1'b1, HTRANS_NONSEQ, 1'b1, a, s, d, 1'b0, '0, '0, acc);
    endtask

    task automatic rd(input logic [31:0] a);
        logic acc;
        cycle(1'b1, HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD, '0, 1'b0, '0, '0, acc);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            cycle(1'b0, HTRANS_IDLE, 1'b0, '0, HSIZE_WORD, '0, 1'b0, '0, '0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0, li, k, guard;
        logic acc;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        drive(1'b0, HTRANS_IDLE, 1'b0, '0, HSIZE_WORD, '0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("rst_wea", 32'(bram_wea), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        rst = 1'b0;

        // Reset during a write data phase drops the write.
        wr(32'h40, HSIZE_WORD, 32'hCAFE_F00D);
        bus.HWDATA = 32'hCAFE_F00D;
        #1;
        check("pre_rst_wea", 32'(bram_wea), 32'hF);
        rst = 1'b1;
        #1;
        check("midrst_wea", 32'(bram_wea), 32'd0);
        check("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        p_valid = 1'b0;
        rd(32'h40); idle(1);
        check("midrst_readback", last_rd, 32'h0);

        // Word write then zero-wait read.
        wr(32'h40, HSIZE_WORD, 32'h1234_5678); idle(1);
        s0 = stall_cnt;
        rd(32'h40); idle(1);
        check("word_rd", last_rd, 32'h1234_5678);
        check("word_no_stall", 32'(stall_cnt - s0), 32'd0);

        // Byte and half-word lanes.
        wr(32'h40, HSIZE_WORD, 32'hFFFF_FFFF); idle(1);
        wr(32'h43, HSIZE_BYTE, 32'hAB00_0000);
        wr(32'h40, HSIZE_HALF, 32'h0000_CDEF); idle(1);
        rd(32'h40); idle(1);
        check("lanes_rd", last_rd, 32'hABFF_CDEF);

        // Read immediately after a write to the same word stalls once.
        s0 = stall_cnt;
        wr(32'h80, HSIZE_WORD, 32'hDEAD_BEEF);
        rd(32'h80); idle(2);
        check("raw_stalls", 32'(stall_cnt - s0), 32'd1);
        check("raw_rd", last_rd, 32'hDEAD_BEEF);

        // Loader stream alongside a 4-beat CPU write burst.
        li = 0; k = 0; guard = 0;
        while ((li < 8 || k < 5) && guard < 100) begin
            if (k < 4)
                cycle(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 32'h200 + 32'(4*k), HSIZE_WORD,
                      32'hA000_0000 + 32'(k), li < 8, AW'(li), 32'h1000 + 32'(li), acc);
            else
                cycle(1'b0, HTRANS_IDLE, 1'b0, '0, HSIZE_WORD, '0, li < 8, AW'(li), 32'h1000 + 32'(li), acc);
            if (acc) li++;
            k++; guard++;
        end
        check("loader_done", 32'(li), 32'd8);
        for (int i = 0; i < 8; i++) rd(32'(4*i));
        for (int i = 0; i < 4; i++) rd(32'h200 + 32'(4*i));
        idle(1);
        check("burst_last_rd", last_rd, 32'hA000_0003);

        // Loader write to the word a CPU read targets in the same cycle.
        s0 = stall_cnt;
        cycle(1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, HSIZE_WORD, '0, 1'b1, AW'(32'h20), 32'h5555_AAAA, acc);
        idle(2);
        check("ld_hz_stalls", 32'(stall_cnt - s0), 32'd1);
        check("ld_hz_rd", last_rd, 32'h5555_AAAA);

        // Random traffic over a small window to provoke hazards and aliasing.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 255), 14'(0)} | 32'({$urandom_range(0, 15), 2'($urandom_range(0, 3))});
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
                  3'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 15)), $urandom, acc);
        end
        idle(2);
        for (int i = 0; i < 16; i++) rd(32'(4*i));
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
